// File: rtl/ex_operand_stage.sv
// EX operand stage: picks operands A/B from the register file, forwarding sources, PC or immediate,
// and holds them in a one-entry valid/ready buffer with flush and a saturating stall counter.
module ex_operand_stage #(
    parameter int              XLEN     = 32,
    parameter int              NUM_FWD  = 2,
    parameter int              SEL_W    = 2,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              CNT_W    = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [XLEN-1:0]         rd1_i,
    input  logic [XLEN-1:0]         rd2_i,
    input  logic [XLEN-1:0]         imm_i,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
    input  logic [SEL_W-1:0]        fwd_a_sel_i,
    input  logic [SEL_W-1:0]        fwd_b_sel_i,
    input  logic                    a_pc_i,
    input  logic                    b_imm_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         op_a_o,
    output logic [XLEN-1:0]         op_b_o,
    output logic [XLEN-1:0]         store_data_o,
    output logic [XLEN-1:0]         pc_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    // Selector 0 is the register file, k selects source k-1, anything beyond NUM_FWD yields zero.
    function automatic logic [XLEN-1:0] fwd_pick(
        input logic [SEL_W-1:0]        sel,
        input logic [XLEN-1:0]         rf,
        input logic [NUM_FWD*XLEN-1:0] srcs
    );
        logic [XLEN-1:0] r;
        r = '0;
        if (sel == '0) begin
            r = rf;
        end
        for (int k = 0; k < NUM_FWD; k++) begin
            if (sel == SEL_W'(k + 1)) begin
                r = srcs[k*XLEN +: XLEN];
            end
        end
        return r;
    endfunction

    logic [XLEN-1:0] fa;
    logic [XLEN-1:0] fb;
    logic [XLEN-1:0] a_next;
    logic [XLEN-1:0] b_next;
    logic            accept;
    logic            stalled;

    always_comb begin
        fa     = fwd_pick(fwd_a_sel_i, rd1_i, fwd_data_i);
        fb     = fwd_pick(fwd_b_sel_i, rd2_i, fwd_data_i);
        a_next = a_pc_i ? pc_i : fa;
        b_next = b_imm_i ? imm_i : fb;
    end

    assign in_ready_o = !out_valid_o || out_ready_i || flush_i;
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign stalled    = out_valid_o && !out_ready_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            out_valid_o  <= 1'b0;
            op_a_o       <= '0;
            op_b_o       <= '0;
            store_data_o <= '0;
            pc_o         <= RESET_PC;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o  <= 1'b1;
            op_a_o       <= a_next;
            op_b_o       <= b_next;
            store_data_o <= fb;
            pc_o         <= pc_i;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            stall_cnt_o <= '0;
        end else if (stalled && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule
